// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares a single-port memory between fetch and data requesters
//
// Purpose: grants one requester per cycle to a 1024 x 32 single-port memory.
// Data accesses win by default. A deferral counter forces a fetch grant after
// MAX_DEFER denied cycles. A flush input drops an in-flight fetch response.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   if_req/if_addr/if_flush           fetch request, address, flush
//   if_gnt/if_rvalid/if_rdata         fetch grant and read response
//   dm_req/dm_we/dm_addr/dm_wdata     data request (load/store)
//   dm_gnt/dm_rvalid/dm_rdata         data grant and load response
//   mem_en/mem_we/mem_addr/mem_wdata  memory drive
//   mem_rdata                         memory read data (one cycle after read)
//   conflict_cnt                      saturating count of contention cycles
module mem_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_DEFER = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       conflict_cnt
);

   localparam logic [3:0] MAX_D = 4'(MAX_DEFER);

   logic [3:0]        defer_cnt;
   logic              tag_if;
   logic              tag_dm;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   // Grant decision: flush blocks fetch, starved fetch beats data, else data first.
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (if_flush) begin
         dm_gnt = dm_req;
      end else if (defer_cnt == MAX_D && if_req) begin
         if_gnt = 1'b1;
      end else if (dm_req) begin
         dm_gnt = 1'b1;
      end else begin
         if_gnt = if_req;
      end
   end

   always_comb begin
      mem_en    = if_gnt | dm_gnt;
      mem_we    = dm_gnt & dm_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_gnt) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   // Responses are qualified by the registered tag; flush kills the fetch one
   // in the same cycle. Idle rdata outputs hold their last delivered word.
   assign if_rvalid = tag_if & ~if_flush;
   assign dm_rvalid = tag_dm;
   assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
   assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         defer_cnt    <= '0;
         tag_if       <= 1'b0;
         tag_dm       <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         conflict_cnt <= '0;
      end else begin
         tag_if     <= if_gnt;
         tag_dm     <= dm_gnt & ~dm_we;
         if_rdata_q <= if_rdata;
         dm_rdata_q <= dm_rdata;

         // A flushed cycle neither counts as a denial nor resets the count.
         if (if_gnt || !if_req)
            defer_cnt <= '0;
         else if (!if_flush && defer_cnt < MAX_D)
            defer_cnt <= defer_cnt + 4'd1;

         if (if_req && dm_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [9:0]  if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [9:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [15:0] conflict_cnt;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_DEFER(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory array model: synchronous write, one-cycle read latency.
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        is_if;
      logic [31:0] data;
      int          due;
   } resp_t;

   resp_t sb[$];
   int    cyc;
   int    n_assert;
   int    n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at posedge+1, check at posedge+4, advance.
   task automatic step(input logic ir, input logic [9:0] ia, input logic fl,
                       input logic dr, input logic dw, input logic [9:0] da,
                       input logic [31:0] dwd, input logic exp_ig, input logic exp_dg,
                       input logic push);
      resp_t r;
      logic [9:0] exp_addr;
      if_req = ir; if_addr = ia; if_flush = fl;
      dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
      #3;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         if (r.is_if) begin
            chk("if_rvalid", 32'(if_rvalid), 32'd1);
            chk("if_rdata", if_rdata, r.data);
            chk("dm_rvalid_idle", 32'(dm_rvalid), 32'd0);
         end else begin
            chk("dm_rvalid", 32'(dm_rvalid), 32'd1);
            chk("dm_rdata", dm_rdata, r.data);
            chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
         end
      end else begin
         chk("if_rvalid_none", 32'(if_rvalid), 32'd0);
         chk("dm_rvalid_none", 32'(dm_rvalid), 32'd0);
      end
      chk("if_gnt", 32'(if_gnt), 32'(exp_ig));
      chk("dm_gnt", 32'(dm_gnt), 32'(exp_dg));
      chk("mem_en", 32'(mem_en), 32'(exp_ig | exp_dg));
      chk("mem_we", 32'(mem_we), 32'(exp_dg & dw));
      exp_addr = exp_dg ? da : (exp_ig ? ia : 10'd0);
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_dg && dw) begin
         chk("mem_wdata", mem_wdata, dwd);
         ref_mem[da] = dwd;
      end
      if (push && exp_ig)
         sb.push_back('{is_if: 1'b1, data: ref_mem[ia], due: cyc + 1});
      if (push && exp_dg && !dw)
         sb.push_back('{is_if: 1'b0, data: ref_mem[da], due: cyc + 1});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'hA500_0000 + 32'(i * 7);
         ref_mem[i] = 32'hA500_0000 + 32'(i * 7);
      end
      mem[16] = 32'h2800_000A; ref_mem[16] = 32'h2800_000A;
      mem_rdata = 32'd0;
      rst_n = 1'b0;
      if_req = 0; if_addr = 0; if_flush = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("rst_conflict", 32'(conflict_cnt), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      rst_n = 1'b1;

      // Reset asserted while a load at addr 5 is in flight
      step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0);
      if_req = 0; dm_req = 0;
      rst_n = 1'b0;
      #2;
      chk("midrst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("midrst_dm_rdata", dm_rdata, 32'd0);
      chk("midrst_conflict", 32'(conflict_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      idle();
      chk("postrst_dm_rdata", dm_rdata, 32'd0);
      chk("postrst_if_rdata", if_rdata, 32'd0);

      // Fetch alone
      step(1'b1, 10'h10, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      idle();
      chk("fetch_rdata_hold", if_rdata, 32'h2800_000A);

      // Contention with MAX_DEFER=3: D,D,D,I,D
      step(1'b1, 10'h11, 1'b0, 1'b1, 1'b0, 10'h30, 32'd0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 10'h11, 1'b0, 1'b1, 1'b0, 10'h31, 32'd0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 10'h11, 1'b0, 1'b1, 1'b0, 10'h32, 32'd0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 10'h11, 1'b0, 1'b1, 1'b0, 10'h33, 32'd0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 10'h12, 1'b0, 1'b1, 1'b0, 10'h33, 32'd0, 1'b0, 1'b1, 1'b1);
      idle();
      chk("contention_cnt", 32'(conflict_cnt), 32'd5);

      // Store then load
      step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 10'h20, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
      step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'h20, 32'd0, 1'b0, 1'b1, 1'b1);
      idle();
      chk("store_load_data", dm_rdata, 32'hDEAD_BEEF);

      // Flush: fetch granted in N (response dropped), flush with data load in N+1
      step(1'b1, 10'h40, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 10'h41, 1'b1, 1'b1, 1'b0, 10'h21, 32'd0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 10'h41, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      idle();
      chk("flush_conflict", 32'(conflict_cnt), 32'd6);
      chk("queue_drained", 32'(sb.size()), 32'd0);

      // Saturation of the conflict counter
      if_req = 1; if_addr = 10'h50; dm_req = 1; dm_we = 0; dm_addr = 10'h60;
      repeat (65540) @(posedge clk);
      #1;
      if_req = 0; dm_req = 0;
      @(posedge clk);
      #1;
      chk("sat_conflict", 32'(conflict_cnt), 32'h0000_FFFF);
      if_req = 1; dm_req = 1;
      @(posedge clk);
      #1;
      if_req = 0; dm_req = 0;
      #3;
      chk("sat_hold", 32'(conflict_cnt), 32'h0000_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the processor's single-port 1024 x 32 unified memory between the instruction-fetch requester and the load/store (data) requester. Data accesses win by default, and a deferral counter guarantees fetch forward progress. A flush input discards a fetch response already in flight when a branch is taken. The arbiter sits between the pipeline's IF/MEM stages and the memory array, and its conflict counter provides a performance statistic.

## Interface
Parameters:
- ADDR_W, 10, memory word-address width (1024 words)
- DATA_W, 32, data width
- MAX_DEFER, 3, consecutive denied fetch cycles before fetch is forced priority (legal 1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; holds until if_gnt
- if_addr  in  ADDR_W  fetch word address; stable while if_req is high
- if_flush  in  1  discard the in-flight fetch response; block fetch grant this cycle
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request; holds until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  dm_rdata valid for a load (registered)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1
- conflict_cnt  out  16  saturating count of cycles in which both if_req and dm_req were high

## Operation
- At most one grant per cycle; if_gnt and dm_gnt are never both 1.
- Grant decision (combinational, from current inputs and registered defer_cnt):
  - if_flush=1: dm_gnt=dm_req, if_gnt=0.
  - Otherwise, if defer_cnt == MAX_DEFER and if_req=1: if_gnt=1, dm_gnt=0.
  - Otherwise, if dm_req=1: dm_gnt=1.
  - Otherwise: if_gnt=if_req.
- Memory drive: mem_en = if_gnt | dm_gnt. mem_we = dm_gnt & dm_we. mem_addr and mem_wdata are muxed from the granted requester. When nothing is granted, mem_addr and mem_wdata are 0.
- defer_cnt (4-bit, internal) update:
  - Cleared when if_gnt=1 or if_req=0.
  - Incremented when if_req=1, if_gnt=0 and if_flush=0.
  - Holds when if_flush=1 and if_req=1.
  - Never exceeds MAX_DEFER.
- Response tag: registered 2-bit tag = {read issued to fetch, read issued to data}, set at grant. Stores set no tag.
- Next cycle: if_rvalid = tag_if & ~if_flush; dm_rvalid = tag_dm. The valid rdata output takes mem_rdata; the idle rdata output holds its previous value.
- Flush: if_flush in cycle N suppresses if_rvalid in cycle N (response of a cycle N-1 grant) and prevents a fetch grant in N. The data path is unaffected.
- conflict_cnt increments each cycle with if_req & dm_req, and saturates at 16'hFFFF.

## Timing
- Reset (rst_n=0, async): defer_cnt=0, tags=0, if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, conflict_cnt=0. Combinational grants follow inputs, but registered state is held at reset values.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1. Back-to-back grants give one response per cycle.
- Store: completes in its grant cycle; there is no response.
- Reset asserted mid-operation: a pending response is dropped and no rvalid follows deassertion. The first grant after reset is evaluated normally.
- Fetch worst-case wait under continuous dm_req: MAX_DEFER denied cycles, then a grant on cycle MAX_DEFER+1.
- Simultaneous if_flush and a pending fetch response: the response is suppressed. The data response in the same cycle is unaffected.

## Test plan
- Reset: drive rst_n=0 mid-load (dm grant at addr 5) -> after release, dm_rvalid=0, conflict_cnt=0, all rdata=0.
- Fetch alone: if_req at addr 0x10 with mem[0x10]=0x2800000A -> if_gnt the same cycle, next cycle if_rvalid=1 and if_rdata=0x2800000A.
- Contention: both requesters high for 5 cycles, MAX_DEFER=3, dm_we=0 -> grants D,D,D,I,D; conflict_cnt=5; responses arrive in grant order, one cycle later.
- Store then load: dm store 0xDEADBEEF to addr 0x20, then load addr 0x20 -> mem_we=1 in the first cycle; dm_rvalid=1 with 0xDEADBEEF in the third cycle.
- Flush: fetch granted in cycle N, if_flush=1 in N+1 with if_req=1 -> no if_rvalid in N+1, no if_gnt in N+1, fetch granted in N+2.
- Saturation: force 65540 contention cycles -> conflict_cnt stays at 16'hFFFF.
